// File: rtl/spi_disp_pkg.sv
// Shared definitions for the display SPI sequencer: ROM entry layout, entry
// type codes and the sequencer state encoding.
package spi_disp_pkg;

    localparam int ENTRY_W = 10;

    typedef enum logic [1:0] {
        T_CMD  = 2'b00,
        T_DATA = 2'b01,
        T_DLY  = 2'b10,
        T_END  = 2'b11
    } entry_type_t;

    typedef enum logic [2:0] {
        RST_WAIT = 3'd0,
        FETCH    = 3'd1,
        START    = 3'd2,
        XFER     = 3'd3,
        DELAY    = 3'd4,
        RUN      = 3'd5
    } state_t;

    function automatic logic [ENTRY_W-1:0] make_entry(entry_type_t t, logic [7:0] v);
        return {t, v};
    endfunction

endpackage

// File: rtl/spi_disp_init_rom.sv
// Display power-up script: sleep-out, 1 ms settle, display-on.
// Unlisted addresses read as end-of-script.
module spi_disp_init_rom
    import spi_disp_pkg::*;
(
    input  logic [4:0]         addr,
    output logic [ENTRY_W-1:0] entry
);

    // Combinational script lookup
    always_comb begin
        case (addr)
            5'd0:    entry = make_entry(T_CMD, 8'h11);
            5'd1:    entry = make_entry(T_DLY, 8'h01);
            5'd2:    entry = make_entry(T_CMD, 8'h29);
            5'd3:    entry = make_entry(T_END, 8'h00);
            default: entry = make_entry(T_END, 8'h00);
        endcase
    end

endmodule

// File: rtl/spi_disp_sequencer.sv
// Feeds the SPI TX engine: plays the init ROM script after reset, then drains
// a {dc,data} byte FIFO. Byte completion is tracked through the engine's cs.
module spi_disp_sequencer
    import spi_disp_pkg::*;
#(
    parameter logic [7:0] SCL_DIV     = 8'h1A,
    parameter int         CLK_PER_MS  = 100000,
    parameter int         FIFO_DEPTH  = 16,
    parameter int         ROM_LEN     = 32,
    parameter int         ACK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_dc,
    input  logic [7:0] wr_data,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       init_done,
    output logic       busy,
    output logic       err_timeout,
    output logic [9:0] tx_control,
    output logic [7:0] tx_data,
    input  logic       tx_cs
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(ROM_LEN) + 1;
    localparam int TMO_W = $clog2(ACK_TIMEOUT);

    state_t               state_r, state_nxt_s;
    logic [8:0]           fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic                 push_s, fifo_full_s, fifo_empty_s;
    logic [IDX_W-1:0]     rom_idx_r;
    logic [ENTRY_W-1:0]   rom_entry_s;
    entry_type_t          rom_type_s;
    logic [7:0]           rom_val_s;
    logic                 rom_end_s;
    logic [TMO_W-1:0]     tmo_cnt_r;
    logic [31:0]          dly_cnt_r;
    logic                 start_r, dc_r, init_done_r, err_r;
    logic [7:0]           tx_data_r;
    logic                 fetch_s, load_rom_s, load_fifo_s, dly_load_s;
    logic                 set_init_s, set_err_s, clr_start_s;

    spi_disp_init_rom u_rom (
        .addr  (rom_idx_r[IDX_W-2:0]),
        .entry (rom_entry_s)
    );

    assign rom_type_s   = entry_type_t'(rom_entry_s[ENTRY_W-1 -: 2]);
    assign rom_val_s    = rom_entry_s[7:0];
    assign rom_end_s    = (rom_idx_r >= IDX_W'(ROM_LEN));
    assign fifo_full_s  = (count_r == CNT_W'(FIFO_DEPTH));
    assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
    assign push_s       = wr_en & ~fifo_full_s;

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {wr_dc, wr_data};
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps the count
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (load_fifo_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, load_fifo_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RST_WAIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_nxt_s = state_r;
        fetch_s     = 1'b0;
        load_rom_s  = 1'b0;
        load_fifo_s = 1'b0;
        dly_load_s  = 1'b0;
        set_init_s  = 1'b0;
        set_err_s   = 1'b0;
        clr_start_s = 1'b0;
        case (state_r)
            RST_WAIT: begin
                // a byte left in flight by reset must finish before the script restarts
                if (tx_cs) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = RST_WAIT;
                end
            end
            FETCH: begin
                if (rom_end_s) begin
                    set_init_s  = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    fetch_s = 1'b1;
                    case (rom_type_s)
                        T_CMD, T_DATA: begin
                            load_rom_s  = 1'b1;
                            state_nxt_s = START;
                        end
                        T_DLY: begin
                            if (rom_val_s != 8'd0) begin
                                dly_load_s  = 1'b1;
                                state_nxt_s = DELAY;
                            end else begin
                                state_nxt_s = FETCH;
                            end
                        end
                        T_END: begin
                            set_init_s  = 1'b1;
                            state_nxt_s = RUN;
                        end
                        default: state_nxt_s = RUN;
                    endcase
                end
            end
            START: begin
                if (!tx_cs) begin
                    clr_start_s = 1'b1;
                    state_nxt_s = XFER;
                end else if (tmo_cnt_r == TMO_W'(ACK_TIMEOUT - 1)) begin
                    set_err_s   = 1'b1;
                    clr_start_s = 1'b1;
                    state_nxt_s = init_done_r ? RUN : FETCH;
                end else begin
                    state_nxt_s = START;
                end
            end
            XFER: begin
                if (tx_cs) begin
                    state_nxt_s = init_done_r ? RUN : FETCH;
                end else begin
                    state_nxt_s = XFER;
                end
            end
            DELAY: begin
                if (dly_cnt_r == 32'd1) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = DELAY;
                end
            end
            RUN: begin
                if (!fifo_empty_s) begin
                    load_fifo_s = 1'b1;
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = RST_WAIT;
        endcase
    end

    // Engine-facing byte/dc/start registers, script index, timers and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_idx_r   <= {IDX_W{1'b0}};
            tx_data_r   <= 8'h00;
            dc_r        <= 1'b0;
            start_r     <= 1'b0;
            tmo_cnt_r   <= {TMO_W{1'b0}};
            dly_cnt_r   <= 32'd0;
            init_done_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            if (fetch_s) begin
                rom_idx_r <= rom_idx_r + IDX_W'(1);
            end
            if (load_rom_s) begin
                tx_data_r <= rom_val_s;
                dc_r      <= (rom_type_s == T_DATA);
                start_r   <= 1'b1;
            end else if (load_fifo_s) begin
                {dc_r, tx_data_r} <= fifo_mem_r[rd_ptr_r];
                start_r           <= 1'b1;
            end else if (clr_start_s) begin
                start_r <= 1'b0;
            end
            if (load_rom_s || load_fifo_s) begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end else if (state_r == START) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
            if (dly_load_s) begin
                dly_cnt_r <= 32'(rom_val_s) * 32'(CLK_PER_MS);
            end else if (state_r == DELAY) begin
                dly_cnt_r <= dly_cnt_r - 32'd1;
            end
            if (set_init_s) begin
                init_done_r <= 1'b1;
            end
            if (set_err_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign tx_control  = {SCL_DIV, dc_r, start_r};
    assign tx_data     = tx_data_r;
    assign init_done   = init_done_r;
    assign err_timeout = err_r;
    assign fifo_full   = fifo_full_s;
    assign fifo_empty  = fifo_empty_s;
    assign busy        = (state_r == START) || (state_r == XFER) || (state_r == DELAY) ||
                         ((state_r == RUN) && !fifo_empty_s);

endmodule

// File: tb/tb_spi_disp_sequencer.sv
// Self-checking bench for spi_disp_sequencer with a behavioural SPI engine model
// and a queue-based reference of the bytes that must reach the engine.
module tb_spi_disp_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic       wr_dc = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_cs = 1'b1;
    logic       fifo_full, fifo_empty, init_done, busy, err_timeout;
    logic [9:0] tx_control;
    logic [7:0] tx_data;

    spi_disp_sequencer #(.CLK_PER_MS(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_dc       (wr_dc),
        .wr_data     (wr_data),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .init_done   (init_done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .tx_control  (tx_control),
        .tx_data     (tx_data),
        .tx_cs       (tx_cs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dc;
        logic [7:0] data;
        logic       exp_full;
        logic       exp_empty;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [8:0] sent_q[$];
    int         gap_q[$];
    int         last_rise = -1;
    int         rise_cnt = 0;
    bit         eng_en = 1'b1;
    int         lat_max = 3;
    int         len_min = 3;
    int         len_max = 8;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sent_at(int i);
        if (i < sent_q.size()) return 32'(sent_q[i]);
        else return 32'hDEAD;
    endfunction

    function automatic int gap_at(int i);
        if (i < gap_q.size()) return gap_q[i];
        else return -1;
    endfunction

    // SPI engine model: sees start, lowers cs after a random latency, holds it
    // for a random byte time, and logs {dc,data} captured when cs falls.
    initial begin
        int         st;
        int         cnt;
        logic [8:0] cap;
        bit         cap_ok;
        st = 0; cnt = 0; cap = 9'h000; cap_ok = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (reset) cap_ok = 1'b0;
            case (st)
                0: begin
                    if (eng_en && tx_control[0] && !reset) begin
                        if (last_rise >= 0) begin
                            gap_q.push_back(cyc - last_rise);
                            chk("byte_gap", 32'((cyc - last_rise) >= 2), 32'd1);
                        end
                        cnt = int'($urandom_range(lat_max, 0));
                        st = 1;
                    end
                end
                1: begin
                    if (cnt == 0) begin
                        tx_cs = 1'b0;
                        cap = {tx_control[1], tx_data};
                        sent_q.push_back(cap);
                        cap_ok = 1'b1;
                        cnt = int'($urandom_range(len_max, len_min));
                        st = 2;
                    end else begin
                        if (!reset) chk("start_hold", 32'(tx_control[0]), 32'd1);
                        cnt--;
                    end
                end
                default: begin
                    if (cap_ok) chk("byte_stable", 32'({tx_control[1], tx_data}), 32'(cap));
                    cnt--;
                    if (cnt <= 0) begin
                        tx_cs = 1'b1;
                        last_rise = cyc;
                        rise_cnt++;
                        st = 0;
                    end
                end
            endcase
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        last_rise = -1;
        repeat (2) @(negedge clk);
        sent_q.delete();
        gap_q.delete();
        reset = 1'b0;
    endtask

    task automatic push(logic dc, logic [7:0] d);
        wr_en = 1'b1;
        wr_dc = dc;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t       vec [17];
        logic [8:0] exp2 [3];
        logic [8:0] exp_q[$];
        int         base;
        int         n;
        logic       rdc;
        logic [7:0] rdata;

        for (int i = 0; i < 17; i++) begin
            vec[i].dc        = i[0];
            vec[i].data      = 8'(8'h40 + i);
            vec[i].exp_full  = (i >= 15);
            vec[i].exp_empty = 1'b0;
        end
        exp2[0] = {1'b1, 8'hA5};
        exp2[1] = {1'b0, 8'h2C};
        exp2[2] = {1'b1, 8'hFF};

        // Reset state and init script
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_tx_control", 32'(tx_control), 32'({8'h1A, 2'b00}));
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_fifo_empty", 32'(fifo_empty), 32'd1);
        chk("rst_fifo_full", 32'(fifo_full), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        sent_q.delete();
        gap_q.delete();
        reset = 1'b0;
        for (int k = 0; k < 3000 && !init_done; k++) @(negedge clk);
        chk("init_done", 32'(init_done), 32'd1);
        chk("init_nbytes", 32'(sent_q.size()), 32'd2);
        chk("init_b0", sent_at(0), 32'({1'b0, 8'h11}));
        chk("init_b1", sent_at(1), 32'({1'b0, 8'h29}));
        chk("init_dly_gap", 32'(gap_at(0) >= 10), 32'd1);
        chk("init_idle_busy", 32'(busy), 32'd0);

        // Back-to-back pushes after init
        sent_q.delete();
        base = rise_cnt;
        for (int i = 0; i < 3; i++) push(exp2[i][8], exp2[i][7:0]);
        for (int k = 0; k < 2000 && rise_cnt < base + 3; k++) @(negedge clk);
        chk("b2b_done", 32'(rise_cnt - base), 32'd3);
        chk("b2b_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2b_busy_drop", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) chk("b2b_byte", sent_at(i), 32'(exp2[i]));

        // Fill the FIFO during init from the vector table
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_dc = vec[i].dc;
            wr_data = vec[i].data;
            @(negedge clk);
            chk("fill_full", 32'(fifo_full), 32'(vec[i].exp_full));
            chk("fill_empty", 32'(fifo_empty), 32'(vec[i].exp_empty));
        end
        wr_en = 1'b0;
        chk("fill_pre_init", 32'(init_done), 32'd0);
        for (int k = 0; k < 5000 && !(init_done && !busy); k++) @(negedge clk);
        chk("fill_nbytes", 32'(sent_q.size()), 32'd18);
        for (int i = 0; i < 16; i++) chk("fill_byte", sent_at(i + 2), 32'({vec[i].dc, vec[i].data}));

        // Push and pop in the same cycle at count 1
        sent_q.delete();
        base = rise_cnt;
        wr_en = 1'b1; wr_dc = 1'b0; wr_data = 8'h3C;
        @(negedge clk);
        wr_dc = 1'b1; wr_data = 8'hC3;
        @(negedge clk);
        wr_en = 1'b0;
        chk("pp_not_empty", 32'(fifo_empty), 32'd0);
        chk("pp_not_full", 32'(fifo_full), 32'd0);
        for (int k = 0; k < 2000 && !(rise_cnt >= base + 2 && !busy); k++) @(negedge clk);
        chk("pp_empty_end", 32'(fifo_empty), 32'd1);
        chk("pp_nbytes", 32'(sent_q.size()), 32'd2);
        chk("pp_b0", sent_at(0), 32'({1'b0, 8'h3C}));
        chk("pp_b1", sent_at(1), 32'({1'b1, 8'hC3}));

        // Random bursts against the queue reference (pointers wrap)
        sent_q.delete();
        exp_q.delete();
        for (int b = 0; b < 6; b++) begin
            n = int'($urandom_range(8, 1));
            for (int j = 0; j < n; j++) begin
                rdc = 1'($urandom_range(1, 0));
                rdata = 8'($urandom_range(255, 0));
                push(rdc, rdata);
                exp_q.push_back({rdc, rdata});
                repeat ($urandom_range(2, 0)) @(negedge clk);
            end
            for (int k = 0; k < 3000 && busy; k++) @(negedge clk);
        end
        chk("rnd_nbytes", 32'(sent_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) chk("rnd_byte", sent_at(i), 32'(exp_q[i]));

        // Engine never answers: timeout, script continues, flag sticky
        eng_en = 1'b0;
        do_reset();
        for (int k = 0; k < 50 && !tx_control[0]; k++) @(negedge clk);
        chk("tmo_start", 32'(tx_control[0]), 32'd1);
        chk("tmo_b0", 32'({tx_control[1], tx_data}), 32'({1'b0, 8'h11}));
        n = 0;
        while (n < 1200 && !err_timeout) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'd1024);
        chk("tmo_start_drop", 32'(tx_control[0]), 32'd0);
        for (int k = 0; k < 100 && !tx_control[0]; k++) @(negedge clk);
        chk("tmo_next", 32'({tx_control[0], tx_control[1], tx_data}), 32'({1'b1, 1'b0, 8'h29}));
        chk("tmo_sticky", 32'(err_timeout), 32'd1);
        sent_q.delete();
        eng_en = 1'b1;
        for (int k = 0; k < 500 && !init_done; k++) @(negedge clk);
        chk("tmo_init_done", 32'(init_done), 32'd1);
        chk("tmo_sticky_end", 32'(err_timeout), 32'd1);
        chk("tmo_sent", sent_at(0), 32'({1'b0, 8'h29}));
        do_reset();
        chk("tmo_clr", 32'(err_timeout), 32'd0);

        // Reset while a byte is in flight
        len_min = 20;
        len_max = 20;
        do_reset();
        for (int k = 0; k < 50 && tx_cs; k++) @(negedge clk);
        chk("mid_cs_low", 32'(tx_cs), 32'd0);
        reset = 1'b1;
        last_rise = -1;
        @(negedge clk);
        chk("mid_start_drop", 32'(tx_control), 32'({8'h1A, 2'b00}));
        reset = 1'b0;
        sent_q.delete();
        gap_q.delete();
        for (int k = 0; k < 100 && !tx_cs; k++) begin
            chk("mid_no_fetch", 32'({tx_control[0], busy}), 32'd0);
            @(negedge clk);
        end
        chk("mid_cs_high", 32'(tx_cs), 32'd1);
        len_min = 3;
        len_max = 8;
        for (int k = 0; k < 3000 && !init_done; k++) @(negedge clk);
        chk("mid_init_done", 32'(init_done), 32'd1);
        chk("mid_nbytes", 32'(sent_q.size()), 32'd2);
        chk("mid_b0", sent_at(0), 32'({1'b0, 8'h11}));
        chk("mid_b1", sent_at(1), 32'({1'b0, 8'h29}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
